// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg
// Shared definitions for the RV32I register-file slice:
//   XLEN_DEFAULT : default integer register width
//   REG_ZERO     : index of the hardwired-zero register x0
//   state_t      : clear-sequencer states (ST_INIT clears, ST_RUN = usable)
// ---------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int REG_ZERO     = 0;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// ---------------------------------------------------------------------------
// rf_clear_seq
// Walks the register array once after reset (or on clear_req), writing zero
// to one entry per cycle, then declares the file ready.
// Ports:
//   clock     in   rising-edge clock
//   reset_n   in   asynchronous active-low reset
//   clear_req in   restarts the clear walk from entry 0
//   clr_we    out  clear write strobe (high for the whole INIT state)
//   clr_addr  out  entry being cleared this cycle
//   ready     out  1 once every entry has been cleared (state RUN)
// ---------------------------------------------------------------------------
module rf_clear_seq
    import rv32i_pkg::*;
#(
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic          ready
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    state_t        state_reg;
    logic [AW-1:0] clr_ptr_reg;
    logic          ready_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_INIT;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
        end else if (clear_req) begin
            // Restart from entry 0 whether we were clearing or running.
            state_reg   <= ST_INIT;
            clr_ptr_reg <= '0;
            ready_reg   <= 1'b0;
        end else if (state_reg == ST_INIT) begin
            if (clr_ptr_reg == LAST_ADDR) begin
                state_reg   <= ST_RUN;
                clr_ptr_reg <= '0;
                ready_reg   <= 1'b1;
            end else begin
                clr_ptr_reg <= clr_ptr_reg + AW'(1);
            end
        end
    end

    assign clr_we   = (state_reg == ST_INIT);
    assign clr_addr = clr_ptr_reg;
    assign ready    = ready_reg;

endmodule

// File: rtl/reg_file_mp.sv
// ---------------------------------------------------------------------------
// reg_file_mp
// Multi-read-port RV32I integer register file with x0 hardwired to zero,
// optional write-through bypass and a per-register pending scoreboard.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   clear_req  in   pulse: re-run the clear sequence
//   ready      out  file usable
//   rd_we      in   write-back enable
//   rd_addr    in   write-back address
//   rd_in      in   write-back data
//   sb_set     in   mark sb_addr as pending (producer issued)
//   sb_addr    in   scoreboard set address
//   rs_addr    in   NRP packed read addresses, port k at [k*AW +: AW]
//   rs_data    out  NRP packed read data, port k at [k*XLEN +: XLEN]
//   rs_pending out  pending bit of each port's register
// ---------------------------------------------------------------------------
module reg_file_mp
    import rv32i_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEFAULT,
    parameter  int NREGS  = 32,
    parameter  int NRP    = 2,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clear_req,
    output logic                ready,
    input  logic                rd_we,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     rd_in,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr,
    input  logic [NRP*AW-1:0]   rs_addr,
    output logic [NRP*XLEN-1:0] rs_data,
    output logic [NRP-1:0]      rs_pending
);

    localparam logic [AW:0] NREGS_W = (AW + 1)'(NREGS);

    // Architecturally visible register: not x0 and inside the array.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != AW'(REG_ZERO)) && ({1'b0, a} < NREGS_W);
    endfunction

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    rf_clear_seq #(
        .NREGS (NREGS)
    ) u_clear_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .ready     (ready)
    );

    // Normal traffic is only honoured once the clear walk has finished.
    logic wr_ok;
    logic set_ok;

    assign wr_ok  = ready && rd_we  && addr_ok(rd_addr);
    assign set_ok = ready && sb_set && addr_ok(sb_addr);

    // The array carries no reset; the clear sequencer zeroes it instead.
    logic [XLEN-1:0] rf [NREGS];

    always_ff @(posedge clock) begin
        if (clr_we) begin
            rf[clr_addr] <= '0;
        end else if (wr_ok) begin
            rf[rd_addr] <= rd_in;
        end
    end

    logic [NREGS-1:0] pending_reg;
    logic [NREGS-1:0] pending_next;

    always_comb begin
        pending_next = pending_reg;
        if (!ready || clear_req) begin
            pending_next = '0;
        end else begin
            if (wr_ok) begin
                pending_next[rd_addr] = 1'b0;
            end
            // Applied after the clear so a newly issued producer wins.
            if (set_ok) begin
                pending_next[sb_addr] = 1'b1;
            end
        end
        pending_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_rd
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] data;
            logic            pend;

            assign addr = rs_addr[gi*AW +: AW];

            always_comb begin
                data = '0;
                pend = 1'b0;
                if (ready && addr_ok(addr)) begin
                    if ((BYPASS != 0) && wr_ok && (rd_addr == addr)) begin
                        // The value being written is the freshest; its
                        // producer has just completed, so nothing is pending.
                        data = rd_in;
                    end else begin
                        data = rf[addr];
                        pend = pending_reg[addr];
                    end
                end
            end

            assign rs_data[gi*XLEN +: XLEN] = data;
            assign rs_pending[gi]           = pend;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// ---------------------------------------------------------------------------
// tb_reg_file_mp
// Three register files share one stimulus stream:
//   inst 0: NREGS=32, NRP=4, BYPASS=1
//   inst 1: NREGS=32, NRP=4, BYPASS=0
//   inst 2: NREGS=24, NRP=2, BYPASS=1 (sees read ports 0 and 1)
// A driver applies each cycle's inputs, predicts every instance's outputs
// from an array-based model and queues them; a monitor pops and compares
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_reg_file_mp;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        clear_req;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_in;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [19:0] rs_addr;

    logic         ready_m, ready_n, ready_s;
    logic [127:0] rs_data_m, rs_data_n;
    logic [63:0]  rs_data_s;
    logic [3:0]   pend_m, pend_n;
    logic [1:0]   pend_s;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRP(4), .BYPASS(1)) dut_m (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .ready(ready_m),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_in(rd_in),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rs_addr(rs_addr), .rs_data(rs_data_m), .rs_pending(pend_m)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRP(4), .BYPASS(0)) dut_n (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .ready(ready_n),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_in(rd_in),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rs_addr(rs_addr), .rs_data(rs_data_n), .rs_pending(pend_n)
    );

    reg_file_mp #(.XLEN(32), .NREGS(24), .NRP(2), .BYPASS(1)) dut_s (
        .clock(clock), .reset_n(reset_n), .clear_req(clear_req), .ready(ready_s),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_in(rd_in),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .rs_addr(rs_addr[9:0]), .rs_data(rs_data_s), .rs_pending(pend_s)
    );

    typedef struct {
        int           inst;
        int           tag;
        logic         rdy;
        logic [127:0] data;
        logic [3:0]   pend;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // ---------------- reference model ----------------
    logic [31:0] m_rf   [3][32];
    logic [31:0] m_pend [3];
    int          m_init [3];   // edges still needed before ready

    function automatic int nregs_of(int i);
        return (i == 2) ? 24 : 32;
    endfunction

    function automatic int nports_of(int i);
        return (i == 2) ? 2 : 4;
    endfunction

    function automatic bit bypass_of(int i);
        return i != 1;
    endfunction

    function automatic bit in_rng(int i, logic [4:0] a);
        return (a != 5'd0) && (int'(a) < nregs_of(i));
    endfunction

    // Contents become zero before ready rises again, so zero them at once.
    task automatic model_reset(int i);
        m_init[i] = nregs_of(i);
        m_pend[i] = '0;
        for (int r = 0; r < 32; r++) m_rf[i][r] = '0;
    endtask

    task automatic model_edge(int i);
        if (!reset_n) begin
            model_reset(i);
            return;
        end
        if (m_init[i] > 0) begin
            if (clear_req) m_init[i] = nregs_of(i);
            else           m_init[i] = m_init[i] - 1;
            return;
        end
        if (rd_we && in_rng(i, rd_addr)) m_rf[i][rd_addr] = rd_in;
        if (clear_req) begin
            model_reset(i);
            return;
        end
        if (rd_we && in_rng(i, rd_addr))  m_pend[i][rd_addr] = 1'b0;
        if (sb_set && in_rng(i, sb_addr)) m_pend[i][sb_addr] = 1'b1;
    endtask

    task automatic push_expect(int i, int tag);
        exp_t       e;
        logic [4:0] a;
        e.inst = i;
        e.tag  = tag;
        e.rdy  = (m_init[i] == 0);
        e.data = '0;
        e.pend = '0;
        for (int k = 0; k < nports_of(i); k++) begin
            a = rs_addr[k*5 +: 5];
            if (e.rdy && in_rng(i, a)) begin
                if (bypass_of(i) && rd_we && rd_addr == a) begin
                    e.data[k*32 +: 32] = rd_in;
                end else begin
                    e.data[k*32 +: 32] = m_rf[i][a];
                    e.pend[k]          = m_pend[i][a];
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input logic rn, input logic cr, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic ss, input logic [4:0] sa,
                         input logic [19:0] ra, input int tag);
        @(posedge clock);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        reset_n   = rn;
        clear_req = cr;
        rd_we     = we;
        rd_addr   = wa;
        rd_in     = wd;
        sb_set    = ss;
        sb_addr   = sa;
        rs_addr   = ra;
        if (!rn) for (int i = 0; i < 3; i++) model_reset(i);
        for (int i = 0; i < 3; i++) push_expect(i, tag);
    endtask

    function automatic logic [19:0] ports(logic [4:0] p3, logic [4:0] p2,
                                          logic [4:0] p1, logic [4:0] p0);
        return {p3, p2, p1, p0};
    endfunction

    // ---------------- monitor ----------------
    task automatic check(string what, int tag, int inst, logic [127:0] got, logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s tag=%0d inst=%0d got=%h want=%h", what, tag, inst, got, want);
        end
    endtask

    initial begin
        exp_t         e;
        logic         r;
        logic [127:0] d;
        logic [3:0]   p;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.inst)
                    0:       begin r = ready_m; d = rs_data_m;          p = pend_m;         end
                    1:       begin r = ready_n; d = rs_data_n;          p = pend_n;         end
                    default: begin r = ready_s; d = {64'd0, rs_data_s}; p = {2'b00, pend_s}; end
                endcase
                check("ready",      e.tag, e.inst, 128'(r), 128'(e.rdy));
                check("rs_data",    e.tag, e.inst, d,       e.data);
                check("rs_pending", e.tag, e.inst, 128'(p), 128'(e.pend));
                if (e.inst == 0)
                    $display("txn tag=%0d t=%0t ready=%b rs_addr=%h rs_data=%h pend=%b",
                             e.tag, $time, r, rs_addr, d, p);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n   = 1'b0;
        clear_req = 1'b0;
        rd_we     = 1'b0;
        rd_addr   = '0;
        rd_in     = '0;
        sb_set    = 1'b0;
        sb_addr   = '0;
        rs_addr   = '0;
        for (int i = 0; i < 3; i++) model_reset(i);

        // T1: reset, then INIT with writes to x5 that must be ignored
        for (int c = 0; c < 3; c++)
            cycle(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, ports(5, 5, 5, 5), 1);
        for (int c = 0; c < 34; c++)
            cycle(1, 0, c < 20, 5'd5, 32'hDEADBEEF, 1, 5'd5, ports(5, 5, 5, 5), 1);

        // T2: write x5, read it on every port next cycle
        cycle(1, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, ports(0, 0, 0, 0), 2);
        cycle(1, 0, 0, 5'd0, 32'h0,        0, 5'd0, ports(5, 5, 5, 5), 2);

        // T3: write x7 while port 1 reads it (bypass vs. old value)
        cycle(1, 0, 1, 5'd7, 32'h12345678, 0, 5'd0, ports(0, 0, 7, 0), 3);
        cycle(1, 0, 0, 5'd0, 32'h0,        0, 5'd0, ports(7, 0, 7, 7), 3);

        // T4: x0 stays zero; address 30 is outside the 24-entry file
        cycle(1, 0, 1, 5'd0,  32'hFFFFFFFF, 0, 5'd0, ports(0, 0, 0, 0), 4);
        cycle(1, 0, 1, 5'd30, 32'hCAFEF00D, 0, 5'd0, ports(0, 0, 0, 0), 4);
        cycle(1, 0, 0, 5'd0,  32'h0,        0, 5'd0, ports(0, 30, 30, 0), 4);

        // T5: scoreboard set, set-wins collision, then clear
        cycle(1, 0, 0, 5'd0, 32'h0,        1, 5'd9, ports(9, 9, 9, 9), 5);
        cycle(1, 0, 0, 5'd0, 32'h0,        0, 5'd0, ports(9, 9, 9, 9), 5);
        cycle(1, 0, 1, 5'd9, 32'h99999999, 1, 5'd9, ports(9, 0, 0, 0), 5);
        cycle(1, 0, 0, 5'd0, 32'h0,        0, 5'd0, ports(9, 9, 9, 9), 5);
        cycle(1, 0, 1, 5'd9, 32'h11112222, 0, 5'd0, ports(0, 0, 0, 0), 5);
        cycle(1, 0, 0, 5'd0, 32'h0,        0, 5'd0, ports(9, 9, 9, 9), 5);

        // T6: clear_req in RUN, then reset pulsed mid-INIT
        cycle(1, 0, 1, 5'd3, 32'hA5A5A5A5, 1, 5'd4, ports(0, 0, 0, 0), 6);
        cycle(1, 0, 0, 5'd0, 32'h0,        1, 5'd6, ports(3, 4, 6, 9), 6);
        cycle(1, 1, 1, 5'd8, 32'h88888888, 0, 5'd0, ports(3, 4, 6, 8), 6);
        for (int c = 0; c < 34; c++)
            cycle(1, 0, 1, 5'd3, 32'h33333333, 1, 5'd4, ports(3, 4, 6, 8), 6);
        cycle(1, 0, 1, 5'd3, 32'hA5A5A5A5, 0, 5'd0, ports(0, 0, 0, 0), 7);
        cycle(1, 1, 0, 5'd0, 32'h0,        0, 5'd0, ports(3, 3, 3, 3), 7);
        for (int c = 0; c < 10; c++)
            cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, ports(3, 3, 3, 3), 7);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, ports(3, 3, 3, 3), 7);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, ports(3, 3, 3, 3), 7);
        for (int c = 0; c < 35; c++)
            cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, ports(3, 3, 8, 4), 7);

        // Randomised traffic with rare clears and resets
        for (int c = 0; c < 1000; c++)
            cycle($urandom_range(0, 399) != 0,
                  $urandom_range(0, 149) == 0,
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  32'($urandom),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  20'($urandom),
                  8);

        @(posedge clock);
        @(negedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
